// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between I-cache refill and data-memory requesters, round-robin, watchdog-protected.
// Latency: grant one cycle after req is seen in IDLE; ready/read-data combinational with i_mem_ack; one IDLE cycle between grants.
// Backpressure: requesters hold req level until their ready strobe; the memory stalls the owner by withholding i_mem_ack (watchdog aborts after TIMEOUT).
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ic_req,
  input  logic [XLEN-1:0] i_ic_addr,
  output logic [XLEN-1:0] o_ic_data,
  output logic            o_ic_ready,
  input  logic            i_dm_req,
  input  logic            i_dm_wen,
  input  logic [XLEN-1:0] i_dm_addr,
  input  logic [XLEN-1:0] i_dm_wdata,
  input  logic [3:0]      i_dm_byte_en,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic            o_dm_ready,
  output logic            o_mem_req,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_byte_en,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_ack,
  output logic            o_owner,
  output logic            o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  // Counter only has to reach TIMEOUT-1; keep at least one bit so the
  // disabled (TIMEOUT=0) and tiny configurations still elaborate.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t          state_q, state_d;
  logic            prio_q, prio_d;     // 1 = D side wins a tie
  logic            owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      ben_q, ben_d;

  logic in_gnt;
  logic expire;
  logic pick_dm;

  assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);
  // Ack takes precedence over expiry, so expiry requires the ack to be absent.
  assign expire = (TIMEOUT != 0) && in_gnt && !i_mem_ack && (cnt_q == CNT_LAST);
  // Tie goes to the prio side; a lone requester always wins.
  assign pick_dm = i_dm_req && (!i_ic_req || prio_q);

  // Next-state: arbitration and latching in IDLE, completion/abort and watchdog count in grant.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    ben_d   = ben_q;
    case (state_q)
      IDLE: begin
        if (i_ic_req || i_dm_req) begin
          cnt_d   = '0;
          owner_d = pick_dm;
          prio_d  = !pick_dm;
          if (pick_dm) begin
            state_d = GNT_D;
            addr_d  = i_dm_addr;
            wen_d   = i_dm_wen;
            wdata_d = i_dm_wdata;
            ben_d   = i_dm_byte_en;
          end else begin
            state_d = GNT_I;
            addr_d  = i_ic_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            ben_d   = 4'hF;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (i_mem_ack || expire) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      ben_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
    end
  end

  // Output mapping: memory side from latched registers, responses straight from the ack path.
  // Reset masks everything so the cycle in which it is asserted is already quiet.
  always_comb begin
    o_mem_req     = !i_rst && in_gnt;
    o_mem_wen     = !i_rst && in_gnt && wen_q;
    o_mem_addr    = (!i_rst && in_gnt) ? addr_q  : '0;
    o_mem_wdata   = (!i_rst && in_gnt) ? wdata_q : '0;
    o_mem_byte_en = (!i_rst && in_gnt) ? ben_q   : 4'h0;
    o_owner       = !i_rst && owner_q;
    o_timeout     = !i_rst && expire;
    o_ic_ready    = !i_rst && (state_q == GNT_I) && (i_mem_ack || expire);
    o_dm_ready    = !i_rst && (state_q == GNT_D) && (i_mem_ack || expire);
    o_ic_data     = (!i_rst && (state_q == GNT_I) && i_mem_ack) ? i_mem_rdata : '0;
    o_dm_rdata    = (!i_rst && (state_q == GNT_D) && i_mem_ack) ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed test-plan scenarios followed by randomized traffic against a transaction-level reference model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later, model advanced on the edge.
// Backpressure: requesters hold req until ready, may abandon before grant; memory acks randomly or never (watchdog).
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int TMO  = 4;

  logic            clk;
  logic            rst;
  logic            ic_req;
  logic [XLEN-1:0] ic_addr;
  logic [XLEN-1:0] ic_data;
  logic            ic_rdy;
  logic            dm_req;
  logic            dm_wen;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic [3:0]      dm_be;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_rdy;
  logic            mem_req;
  logic            mem_wen;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  logic            owner;
  logic            tmo;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the port (-1 nobody, 0 I, 1 D), how long, and what it asked for.
  int              m_gnt;
  int              m_age;
  bit              m_pref_d;
  bit              m_owner;
  bit              m_post_rst;
  bit              m_done;
  bit              m_ic_done;
  bit              m_dm_done;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic            m_wen;
  logic [3:0]      m_be;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ic_req      (ic_req),
    .i_ic_addr     (ic_addr),
    .o_ic_data     (ic_data),
    .o_ic_ready    (ic_rdy),
    .i_dm_req      (dm_req),
    .i_dm_wen      (dm_wen),
    .i_dm_addr     (dm_addr),
    .i_dm_wdata    (dm_wdata),
    .i_dm_byte_en  (dm_be),
    .o_dm_rdata    (dm_rdata),
    .o_dm_ready    (dm_rdy),
    .o_mem_req     (mem_req),
    .o_mem_wen     (mem_wen),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_byte_en (mem_be),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ack     (mem_ack),
    .o_owner       (owner),
    .o_timeout     (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_cycle();
    logic [31:0] e_req, e_wen, e_addr, e_be, e_own, e_tmo, e_icr, e_icd, e_dmr, e_dmd;
    bit active, expire;
    #1;
    active = (m_gnt >= 0);
    expire = active && (m_age == TMO - 1) && !mem_ack;
    m_done = active && (mem_ack || expire);
    e_req  = 32'(active);
    e_wen  = active ? 32'(m_wen) : 32'd0;
    e_addr = active ? m_addr : 32'd0;
    e_be   = active ? 32'(m_be) : 32'd0;
    e_own  = 32'(m_owner);
    e_tmo  = 32'(expire);
    e_icr  = 32'(m_done && m_gnt == 0);
    e_dmr  = 32'(m_done && m_gnt == 1);
    e_icd  = (m_gnt == 0 && mem_ack) ? mem_rdata : 32'd0;
    e_dmd  = (m_gnt == 1 && mem_ack) ? mem_rdata : 32'd0;
    if (rst) begin
      e_req = 0; e_wen = 0; e_addr = 0; e_be = 0; e_own = 0;
      e_tmo = 0; e_icr = 0; e_icd = 0; e_dmr = 0; e_dmd = 0;
      m_done = 1'b0;
    end
    m_ic_done = e_icr[0];
    m_dm_done = e_dmr[0];
    chk("mem_req",  32'(mem_req), e_req);
    chk("mem_wen",  32'(mem_wen), e_wen);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_be",   32'(mem_be), e_be);
    chk("owner",    32'(owner), e_own);
    chk("timeout",  32'(tmo), e_tmo);
    chk("ic_ready", 32'(ic_rdy), e_icr);
    chk("ic_data",  ic_data, e_icd);
    chk("dm_ready", 32'(dm_rdy), e_dmr);
    chk("dm_rdata", dm_rdata, e_dmd);
    if (rst || m_post_rst) chk("mem_wdata_quiet", mem_wdata, 32'd0);
    else if (m_gnt == 1)   chk("mem_wdata", mem_wdata, m_wdata);
  endtask

  // Advance the model across the rising edge using the inputs the DUT just sampled.
  task automatic tick();
    int pick;
    @(posedge clk);
    if (rst) begin
      m_gnt = -1; m_age = 0; m_pref_d = 1'b1; m_owner = 1'b0; m_post_rst = 1'b1;
    end else begin
      m_post_rst = 1'b0;
      if (m_gnt < 0) begin
        if (ic_req && dm_req) pick = m_pref_d ? 1 : 0;
        else if (dm_req)      pick = 1;
        else if (ic_req)      pick = 0;
        else                  pick = -1;
        if (pick >= 0) begin
          m_gnt    = pick;
          m_age    = 0;
          m_owner  = (pick == 1);
          m_pref_d = (pick == 0);
          if (pick == 1) begin
            m_addr = dm_addr; m_wen = dm_wen; m_wdata = dm_wdata; m_be = dm_be;
          end else begin
            m_addr = ic_addr; m_wen = 1'b0; m_wdata = '0; m_be = 4'hF;
          end
        end
      end else if (m_done) begin
        m_gnt = -1;
      end else begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic cyc();
    check_cycle();
    tick();
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dm_req = 1'b0; dm_wen = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_be = 4'h0; mem_rdata = '0; mem_ack = 1'b0;
    m_gnt = -1; m_age = 0; m_pref_d = 1'b1; m_owner = 1'b0; m_post_rst = 1'b1;
    m_done = 1'b0; m_ic_done = 1'b0; m_dm_done = 1'b0;
    m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_be = 4'h0;
    #1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Single I read: req at c0, ack at c3.
    ic_req = 1'b1; ic_addr = 32'h100;
    cyc();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
      check_cycle();
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'h100);
      chk("t1_wen", 32'(mem_wen), 32'd0);
      chk("t1_be", 32'(mem_be), 32'hF);
      if (c == 3) begin
        chk("t1_ic_ready", 32'(ic_rdy), 32'd1);
        chk("t1_ic_data", ic_data, 32'hDEADBEEF);
      end else begin
        chk("t1_ic_ready_early", 32'(ic_rdy), 32'd0);
      end
      tick();
    end
    ic_req = 1'b0; mem_ack = 1'b0;
    check_cycle();
    chk("t1_idle", 32'(mem_req), 32'd0);
    tick();

    // D write with ack in the first grant cycle.
    dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'h12345678; dm_be = 4'b0011;
    check_cycle();
    chk("t2_dm_ready_c0", 32'(dm_rdy), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    check_cycle();
    chk("t2_wen", 32'(mem_wen), 32'd1);
    chk("t2_addr", mem_addr, 32'h2004);
    chk("t2_wdata", mem_wdata, 32'h12345678);
    chk("t2_be", 32'(mem_be), 32'h3);
    chk("t2_dm_ready_c1", 32'(dm_rdy), 32'd1);
    tick();
    dm_req = 1'b0; mem_ack = 1'b0; dm_wen = 1'b0;
    check_cycle();
    chk("t2_dm_ready_c2", 32'(dm_rdy), 32'd0);
    tick();

    // Round-robin from reset: both held, each grant acked immediately -> D, I, D, I.
    rst = 1'b1;
    cyc();
    rst = 1'b0; ic_req = 1'b1; dm_req = 1'b1; ic_addr = 32'h40; dm_addr = 32'h80;
    for (int c = 0; c < 8; c++) begin
      mem_ack = (m_gnt >= 0);
      mem_rdata = 32'h1000 + 32'(c);
      check_cycle();
      chk("rr_mem_req", 32'(mem_req), 32'(c % 2));
      chk("rr_dm_ready", 32'(dm_rdy), 32'(c % 4 == 1));
      chk("rr_ic_ready", 32'(ic_rdy), 32'(c % 4 == 3));
      chk("rr_owner", 32'(owner), 32'(c % 4 == 1 || c % 4 == 2));
      tick();
    end
    ic_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Watchdog: D read never acked, I request pending behind it.
    dm_req = 1'b1; dm_wen = 1'b0; dm_addr = 32'h300; mem_rdata = 32'hFFFF0000;
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) begin ic_req = 1'b1; ic_addr = 32'h500; end
      check_cycle();
      chk("wd_timeout", 32'(tmo), 32'(c == 4));
      chk("wd_dm_ready", 32'(dm_rdy), 32'(c == 4));
      if (c == 4) chk("wd_dm_rdata", dm_rdata, 32'd0);
      tick();
    end
    dm_req = 1'b0;
    check_cycle();
    chk("wd_idle", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    check_cycle();
    chk("wd_next_owner", 32'(owner), 32'd0);
    chk("wd_next_addr", mem_addr, 32'h500);
    chk("wd_next_ic_data", ic_data, 32'h0BADF00D);
    tick();
    ic_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Ack in the same cycle the watchdog would fire: ack wins.
    dm_req = 1'b1; dm_addr = 32'h304;
    for (int c = 0; c <= 4; c++) begin
      if (c == 4) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE0004; end
      check_cycle();
      if (c == 4) begin
        chk("co_timeout", 32'(tmo), 32'd0);
        chk("co_dm_ready", 32'(dm_rdy), 32'd1);
        chk("co_dm_rdata", dm_rdata, 32'hCAFE0004);
      end
      tick();
    end
    dm_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Reset in the second GNT_I cycle with an ack arriving under reset.
    ic_req = 1'b1; ic_addr = 32'h700;
    cyc(); cyc();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    check_cycle();
    chk("rst_ic_ready", 32'(ic_rdy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ic_data", ic_data, 32'd0);
    tick();
    rst = 1'b0; mem_ack = 1'b0; dm_req = 1'b1; dm_wen = 1'b1; dm_addr = 32'h900;
    dm_wdata = 32'h9; dm_be = 4'hC;
    check_cycle();
    chk("rst_after_req", 32'(mem_req), 32'd0);
    chk("rst_after_owner", 32'(owner), 32'd0);
    tick();
    mem_ack = 1'b1;
    check_cycle();
    chk("rst_first_owner", 32'(owner), 32'd1);
    chk("rst_first_addr", mem_addr, 32'h900);
    tick();
    dm_req = 1'b0; mem_ack = 1'b0; dm_wen = 1'b0;
    cyc();
    mem_ack = 1'b1;
    check_cycle();
    chk("rst_second_owner", 32'(owner), 32'd0);
    tick();
    ic_req = 1'b0; mem_ack = 1'b0;
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (m_ic_done) ic_req = 1'b0;
      else if (!ic_req) begin
        if ($urandom_range(2, 0) == 0) begin ic_req = 1'b1; ic_addr = $urandom; end
      end else if (m_gnt != 0 && $urandom_range(19, 0) == 0) ic_req = 1'b0;
      if (m_dm_done) dm_req = 1'b0;
      else if (!dm_req) begin
        if ($urandom_range(2, 0) == 0) begin
          dm_req = 1'b1; dm_addr = $urandom; dm_wdata = $urandom;
          r = $urandom; dm_wen = r[0]; dm_be = r[7:4];
        end
      end else if (m_gnt != 1 && $urandom_range(19, 0) == 0) dm_req = 1'b0;
      mem_ack   = (m_gnt >= 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(9, 0) == 0);
      mem_rdata = $urandom;
      rst       = ($urandom_range(199, 0) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
